ones_frame_accum: RTL and testbench



---
 rtl/ones_frame_accum.sv | 136 +++++++++++++
 tb/tb_ones_frame_accum.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_frame_accum.sv
// Frame accumulator for per-byte ones counts: sums in_num over a frame closed by in_last
// and presents total, beat count and sticky flags on a valid/ready port.
// Optional threshold compare is enabled by defining ONES_FRAME_ACCUM_THRESH_EN.
module ones_frame_accum #(
    parameter int TOTAL_W = 16,
    parameter int BEAT_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_num,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_total,
    output logic [BEAT_W-1:0]  out_beats,
    output logic               out_sat,
`ifdef ONES_FRAME_ACCUM_THRESH_EN
    output logic               out_err,
    input  logic [TOTAL_W-1:0] thresh,
    output logic               out_over
`else
    output logic               out_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [TOTAL_W:0] TOTAL_ONES = {1'b0, {TOTAL_W{1'b1}}};
    localparam logic [BEAT_W:0]  BEAT_ONES  = {1'b0, {BEAT_W{1'b1}}};

    state_t               r_state;
    logic                 r_out_valid;
    logic [TOTAL_W-1:0]   r_total;
    logic [BEAT_W-1:0]    r_beats;
    logic                 r_sat;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_deliver;
    logic                 w_fresh;
    logic                 w_bad_num;
    logic [3:0]           w_eff;
    logic [TOTAL_W-1:0]   w_base_total;
    logic [BEAT_W-1:0]    w_base_beats;
    logic                 w_base_sat;
    logic                 w_base_err;
    logic [TOTAL_W:0]     w_sum_total;
    logic [BEAT_W:0]      w_sum_beats;
    logic                 w_total_sat;
    logic                 w_beats_sat;
    logic [TOTAL_W-1:0]   w_next_total;
    logic [BEAT_W-1:0]    w_next_beats;
    logic                 w_next_sat;
    logic                 w_next_err;

    assign in_ready  = (r_state != HOLD) | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = r_out_valid & out_ready;

    // A beat accepted outside ACCUM starts a new frame: in HOLD it can only be accepted
    // alongside delivery, so the held result must not be folded into the new one.
    assign w_fresh      = (r_state != ACCUM);
    assign w_base_total = w_fresh ? '0 : r_total;
    assign w_base_beats = w_fresh ? '0 : r_beats;
    assign w_base_sat   = w_fresh ? 1'b0 : r_sat;
    assign w_base_err   = w_fresh ? 1'b0 : r_err;

    assign w_bad_num = (in_num > 4'd8);
    assign w_eff     = w_bad_num ? 4'd8 : in_num;

    assign w_sum_total = {1'b0, w_base_total} + {{(TOTAL_W-3){1'b0}}, w_eff};
    assign w_sum_beats = {1'b0, w_base_beats} + {{BEAT_W{1'b0}}, 1'b1};

    // Reaching all-ones counts as saturation; anything beyond clamps there.
    assign w_total_sat  = (w_sum_total >= TOTAL_ONES);
    assign w_beats_sat  = (w_sum_beats >= BEAT_ONES);
    assign w_next_total = w_total_sat ? {TOTAL_W{1'b1}} : w_sum_total[TOTAL_W-1:0];
    assign w_next_beats = w_beats_sat ? {BEAT_W{1'b1}} : w_sum_beats[BEAT_W-1:0];
    assign w_next_sat   = w_base_sat | w_total_sat | w_beats_sat;
    assign w_next_err   = w_base_err | w_bad_num;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_total     <= '0;
            r_beats     <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_total     <= w_next_total;
            r_beats     <= w_next_beats;
            r_sat       <= w_next_sat;
            r_err       <= w_next_err;
            r_state     <= in_last ? HOLD : ACCUM;
            r_out_valid <= in_last;
        end else if ((r_state == HOLD) && w_deliver) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_total     <= '0;
            r_beats     <= '0;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
        end
    end

`ifdef ONES_FRAME_ACCUM_THRESH_EN
    logic r_over;

    // Compared against the final total so the flag lands in HOLD with the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_over <= 1'b0;
        end else if (w_accept) begin
            r_over <= in_last & (w_next_total >= thresh);
        end else if ((r_state == HOLD) && w_deliver) begin
            r_over <= 1'b0;
        end
    end

    assign out_over = r_over;
`endif

    assign out_valid = r_out_valid;
    assign out_total = r_total;
    assign out_beats = r_beats;
    assign out_sat   = r_sat;
    assign out_err   = r_err;

endmodule

// File: tb/tb_ones_frame_accum.sv
// Directed bench for ones_frame_accum: default-width instance plus a 4-bit-total instance
// for saturation. Threshold checks build when ONES_FRAME_ACCUM_THRESH_EN is defined.
module tb_ones_frame_accum;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [3:0]  a_in_num;
    logic [15:0] a_out_total;
    logic [11:0] a_out_beats;
    logic        a_out_sat, a_out_err;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [3:0]  b_in_num;
    logic [3:0]  b_out_total;
    logic [11:0] b_out_beats;
    logic        b_out_sat, b_out_err;

    int vectors;
    int miscompares;

`ifdef ONES_FRAME_ACCUM_THRESH_EN
    logic [15:0] a_thresh;
    logic        a_out_over;
    logic [3:0]  b_thresh;
    logic        b_out_over;
`endif

    ones_frame_accum #(.TOTAL_W(16), .BEAT_W(12)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_num    (a_in_num),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_total (a_out_total),
        .out_beats (a_out_beats),
        .out_sat   (a_out_sat),
`ifdef ONES_FRAME_ACCUM_THRESH_EN
        .out_err   (a_out_err),
        .thresh    (a_thresh),
        .out_over  (a_out_over)
`else
        .out_err   (a_out_err)
`endif
    );

    ones_frame_accum #(.TOTAL_W(4), .BEAT_W(12)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_num    (b_in_num),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_total (b_out_total),
        .out_beats (b_out_beats),
        .out_sat   (b_out_sat),
`ifdef ONES_FRAME_ACCUM_THRESH_EN
        .out_err   (b_out_err),
        .thresh    (b_thresh),
        .out_over  (b_out_over)
`else
        .out_err   (b_out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic a_beat(input logic [3:0] n, input logic l);
        a_in_valid = 1'b1;
        a_in_num   = n;
        a_in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic b_beat(input logic [3:0] n, input logic l);
        b_in_valid = 1'b1;
        b_in_num   = n;
        b_in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        vectors++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        vectors++;
        if (a_out_total !== 16'd0 || a_out_beats !== 12'd0) begin
            miscompares++; $display("FAIL reset_counts: got total %0d beats %0d want 0 0", a_out_total, a_out_beats);
        end
        vectors++;
        if (a_out_sat !== 1'b0 || a_out_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got sat %b err %b want 0 0", a_out_sat, a_out_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        a_out_ready = 1'b1;
        a_beat(4'd3, 1'b0);
        a_beat(4'd8, 1'b0);
        a_beat(4'd0, 1'b0);
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_total !== 16'd11) begin
            miscompares++; $display("FAIL basic_running: got valid %b total %0d want 0 11", a_out_valid, a_out_total);
        end
        a_beat(4'd5, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", a_out_valid); end
        vectors++;
        if (a_out_total !== 16'd16 || a_out_beats !== 12'd4) begin
            miscompares++; $display("FAIL basic_result: got total %0d beats %0d want 16 4", a_out_total, a_out_beats);
        end
        vectors++;
        if (a_out_sat !== 1'b0 || a_out_err !== 1'b0) begin
            miscompares++; $display("FAIL basic_flags: got sat %b err %b want 0 0", a_out_sat, a_out_err);
        end
        a_idle();
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_total !== 16'd0) begin
            miscompares++; $display("FAIL basic_deliver: got valid %b total %0d want 0 0", a_out_valid, a_out_total);
        end
    endtask

    task automatic test_hold();
        a_out_ready = 1'b0;
        a_beat(4'd3, 1'b0);
        a_beat(4'd8, 1'b0);
        a_beat(4'd0, 1'b0);
        a_beat(4'd5, 1'b1);
        a_in_valid = 1'b1;
        a_in_num   = 4'd2;
        a_in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_total !== 16'd16) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got ready %b valid %b total %0d want 0 1 16", i, a_in_ready, a_out_valid, a_out_total);
            end
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        a_beat(4'd7, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_total !== 16'd7 || a_out_beats !== 12'd1) begin
            miscompares++;
            $display("FAIL hold_reload: got valid %b total %0d beats %0d want 1 7 1", a_out_valid, a_out_total, a_out_beats);
        end
        a_idle();
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_total !== 16'd0 || a_out_beats !== 12'd0) begin
            miscompares++;
            $display("FAIL hold_clear: got valid %b total %0d beats %0d want 0 0 0", a_out_valid, a_out_total, a_out_beats);
        end
    endtask

    task automatic test_err();
        a_out_ready = 1'b1;
        a_beat(4'd12, 1'b0);
        a_beat(4'd4, 1'b1);
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_total !== 16'd12 || a_out_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_frame: got valid %b total %0d err %b want 1 12 1", a_out_valid, a_out_total, a_out_err);
        end
        a_beat(4'd2, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_total !== 16'd2 || a_out_beats !== 12'd1 || a_out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_next_frame: got valid %b total %0d beats %0d err %b want 1 2 1 0",
                     a_out_valid, a_out_total, a_out_beats, a_out_err);
        end
        a_idle();
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1;
        a_beat(4'd1, 1'b0);
        a_beat(4'd1, 1'b1);
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_total !== 16'd2 || a_out_beats !== 12'd2) begin
            miscompares++;
            $display("FAIL b2b_first: got valid %b total %0d beats %0d want 1 2 2", a_out_valid, a_out_total, a_out_beats);
        end
        a_beat(4'd3, 1'b0);
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_total !== 16'd3 || a_out_beats !== 12'd1) begin
            miscompares++;
            $display("FAIL b2b_start: got valid %b total %0d beats %0d want 0 3 1", a_out_valid, a_out_total, a_out_beats);
        end
        a_beat(4'd4, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_total !== 16'd7 || a_out_beats !== 12'd2) begin
            miscompares++;
            $display("FAIL b2b_second: got valid %b total %0d beats %0d want 1 7 2", a_out_valid, a_out_total, a_out_beats);
        end
        a_idle();
    endtask

    task automatic test_sat();
        b_out_ready = 1'b1;
        b_beat(4'd8, 1'b0);
        b_beat(4'd8, 1'b0);
        b_beat(4'd1, 1'b1);
        b_in_valid = 1'b0;
        vectors++;
        if (b_out_valid !== 1'b1 || b_out_total !== 4'd15 || b_out_beats !== 12'd3) begin
            miscompares++;
            $display("FAIL sat_result: got valid %b total %0d beats %0d want 1 15 3", b_out_valid, b_out_total, b_out_beats);
        end
        vectors++;
        if (b_out_sat !== 1'b1 || b_out_err !== 1'b0) begin
            miscompares++; $display("FAIL sat_flags: got sat %b err %b want 1 0", b_out_sat, b_out_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        a_out_ready = 1'b1;
        a_beat(4'd3, 1'b0);
        a_beat(4'd4, 1'b0);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_total !== 16'd0 || a_out_beats !== 12'd0 || a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_state: got valid %b total %0d beats %0d ready %b want 0 0 0 1",
                     a_out_valid, a_out_total, a_out_beats, a_in_ready);
        end
        rst_n = 1'b1;
        a_beat(4'd6, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_total !== 16'd6 || a_out_beats !== 12'd1) begin
            miscompares++;
            $display("FAIL midreset_next: got valid %b total %0d beats %0d want 1 6 1", a_out_valid, a_out_total, a_out_beats);
        end
        a_idle();
    endtask

`ifdef ONES_FRAME_ACCUM_THRESH_EN
    task automatic test_thresh();
        a_out_ready = 1'b1;
        a_thresh    = 16'd10;
        a_beat(4'd5, 1'b0);
        a_beat(4'd5, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_over !== 1'b1) begin
            miscompares++; $display("FAIL thresh_over: got valid %b over %b want 1 1", a_out_valid, a_out_over);
        end
        a_idle();
        a_beat(4'd4, 1'b0);
        a_beat(4'd5, 1'b1);
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_over !== 1'b0) begin
            miscompares++; $display("FAIL thresh_under: got valid %b over %b want 1 0", a_out_valid, a_out_over);
        end
        a_idle();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        a_in_valid  = 1'b0;
        a_in_num    = 4'd0;
        a_in_last   = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_num    = 4'd0;
        b_in_last   = 1'b0;
        b_out_ready = 1'b0;
`ifdef ONES_FRAME_ACCUM_THRESH_EN
        a_thresh    = 16'd0;
        b_thresh    = 4'd0;
`endif
        test_reset();
        test_basic_frame();
        test_hold();
        test_err();
        test_back_to_back();
        test_sat();
        test_reset_mid_frame();
`ifdef ONES_FRAME_ACCUM_THRESH_EN
        test_thresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
